mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Round-robin arbiter that shares one 24-bit-address / 12-bit-data memory port between several bus masters. The masters are Processor12 instances, a DMA engine, and a video fetcher. Each master sees a private mem_ready that behaves like a dedicated slow memory. The arbiter sits between the masters and the memory's address/data/wren/rden/ready interface. Ownership changes only on transaction boundaries; a lock input and a bounded hold counter prevent starvation.

Parameters:
PORTS, 2, number of masters (2..8).
ADDR_WIDTH, 24, address width.
DATA_WIDTH, 12, data word width.
MAX_HOLD, 8, max consecutive completed transactions a locked owner may keep ownership while another port waits (>=1).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
port_valid  input  PORTS  master i wants the bus (request pending or lock held).
port_lock  input  PORTS  master i asks to keep ownership after its current transaction.
port_address  input  PORTS*ADDR_WIDTH  per-master address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
port_read  input  PORTS  per-master read strobe.
port_write  input  PORTS  per-master write strobe.
port_data_out  input  PORTS*DATA_WIDTH  per-master write data.
port_ready  output  PORTS  per-master ready/completion.
port_data_in  output  DATA_WIDTH  read data, broadcast to all masters.
mem_address  output  ADDR_WIDTH  to memory.
mem_read  output  1  to memory.
mem_write  output  1  to memory.
mem_data_out  output  DATA_WIDTH  to memory.
mem_data_in  input  DATA_WIDTH  from memory.
mem_ready  input  1  memory completes the current access in this cycle (high when idle).
owner  output  max(1,$clog2(PORTS))  index of the current bus owner.

Behaviour:
- State registers: owner and hold_ctr (width to hold MAX_HOLD). While rst is high: owner=0, hold_ctr=0.
- Memory-side outputs are combinational from the owner's signals, gated by port_valid[owner]:
  - mem_address = port_address[owner] when valid, else 0.
  - mem_write = valid & port_write[owner].
  - mem_read = valid & port_read[owner] & ~port_write[owner]. Write wins if both strobes are set.
  - mem_data_out = port_data_out[owner] when mem_write, else 0.
- While rst is high, all memory-side outputs and port_ready are forced to 0.
- port_ready[i] = (i==owner) & mem_ready. Non-owners always see 0.
- The parked owner sees ready even when idle; this is required because Processor12 drives its strobes only while ready.
- port_data_in = mem_data_in, unregistered.
- Zero added latency: owner accesses pass straight through. Memory wait states appear as port_ready low.
- Masters must hold address, strobes and data stable until their port_ready is seen high.
- completion = port_valid[owner] & (port_read|port_write)[owner] & mem_ready.
- waiting = any port_valid[j], j != owner.
- Handover at a rising edge occurs when waiting is true and any of these holds:
  - (a) ~port_valid[owner]: owner idle; mem_ready is ignored.
  - (b) completion & ~port_lock[owner].
  - (c) completion & hold_ctr == MAX_HOLD-1: forced release of a lock.
- Handover target: the first j with port_valid[j], scanning owner+1, owner+2, ... modulo PORTS (round-robin).
- On handover, hold_ctr is reset to 0.
- Without handover: hold_ctr increments on completion while waiting, saturating at MAX_HOLD-1. It resets to 0 whenever waiting is false.
- No waiting requesters: the owner is parked indefinitely, regardless of its own valid.
- Handover never happens while the owner has a strobe asserted and mem_ready is low. An in-flight slow access always completes to its issuer.
- A new owner's strobes appear on the memory port in the cycle after handover. There is no bubble beyond that one edge.
- Reset asserted mid-access: outputs drop to 0 immediately and the access is abandoned. After release, port 0 owns.

Test Plan:
- Reset/park: rst=1, then release with only port 0 valid and reading address 0o00000100 for 20 cycles -> owner stays 0. port_ready[0] tracks mem_ready; port_ready[1]=0 throughout.
- Alternation: both ports issue back-to-back reads, no locks, 1-cycle memory -> owner toggles 0,1,0,1 after each completion. Each port receives every second ready. Read data matches memory contents.
- Slow memory: port 0 writes 0o1234 to 0o00000010 with mem_ready low for 3 cycles while port 1 waits -> owner stays 0 until mem_ready=1. Memory holds 0o1234, then owner becomes 1.
- Lock/hold: MAX_HOLD=4; port 0 locked with continuous reads while port 1 waits -> exactly 4 port-0 completions, then handover to port 1 and hold_ctr=0.
- Round-robin, PORTS=4: owner=1, ports 0 and 3 valid -> next owner 3, then 0.
- Simultaneous read+write strobes from owner -> mem_write=1, mem_read=0. Reset asserted during a slow access -> all memory outputs 0 in the same cycle, owner=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between several masters
module mem_arbiter #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 12,
    parameter int MAX_HOLD   = 8,
    localparam int OW = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              port_valid,
    input  logic [PORTS-1:0]              port_lock,
    input  logic [PORTS*ADDR_WIDTH-1:0]   port_address,
    input  logic [PORTS-1:0]              port_read,
    input  logic [PORTS-1:0]              port_write,
    input  logic [PORTS*DATA_WIDTH-1:0]   port_data_out,
    output logic [PORTS-1:0]              port_ready,
    output logic [DATA_WIDTH-1:0]         port_data_in,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [DATA_WIDTH-1:0]         mem_data_out,
    input  logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic                          mem_ready,
    output logic [OW-1:0]                 owner
);

    logic [OW-1:0]           owner_q, owner_d;
    logic [HW-1:0]           hold_ctr_q, hold_ctr_d;
    logic                    sel_valid, sel_lock, sel_read, sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [PORTS-1:0]        others;
    logic [2*PORTS-1:0]      rotated;
    logic [OW-1:0]           target;
    logic                    found, completion, waiting, handover, hold_full;

    always_comb begin
        sel_valid = 1'b0;
        sel_lock  = 1'b0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        others    = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (owner_q == OW'(i)) begin
                sel_valid = port_valid[i];
                sel_lock  = port_lock[i];
                sel_read  = port_read[i];
                sel_write = port_write[i];
                sel_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = port_data_out[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                others[i] = port_valid[i];
            end
        end
    end

    // Bit k of rotated is the request of port (owner+k) mod PORTS.
    always_comb begin
        rotated = {port_valid, port_valid} >> owner_q;
        target  = owner_q;
        found   = 1'b0;
        for (int k = 1; k < PORTS; k++) begin
            if (!found && rotated[k]) begin
                target = OW'((int'(owner_q) + k) % PORTS);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        completion = sel_valid & (sel_read | sel_write) & mem_ready;
        waiting    = |others;
        hold_full  = (hold_ctr_q == HW'(MAX_HOLD - 1));
        handover   = waiting & (~sel_valid | (completion & (~sel_lock | hold_full)));
        owner_d    = owner_q;
        hold_ctr_d = hold_ctr_q;
        if (handover) begin
            owner_d    = target;
            hold_ctr_d = '0;
        end else if (!waiting) begin
            hold_ctr_d = '0;
        end else if (completion && !hold_full) begin
            hold_ctr_d = hold_ctr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= '0;
            hold_ctr_q <= '0;
        end else begin
            owner_q    <= owner_d;
            hold_ctr_q <= hold_ctr_d;
        end
    end

    always_comb begin
        mem_address  = (!rst && sel_valid) ? sel_addr : '0;
        mem_write    = !rst & sel_valid & sel_write;
        mem_read     = !rst & sel_valid & sel_read & ~sel_write;
        mem_data_out = mem_write ? sel_data : '0;
        for (int i = 0; i < PORTS; i++) begin
            port_ready[i] = !rst & (owner_q == OW'(i)) & mem_ready;
        end
        port_data_in = mem_data_in;
        owner        = owner_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
    localparam int P  = 4;
    localparam int AW = 24;
    localparam int DW = 12;
    localparam int MH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [P-1:0]      port_valid, port_lock, port_read, port_write, port_ready;
    logic [P*AW-1:0]   port_address;
    logic [P*DW-1:0]   port_data_out;
    logic [DW-1:0]     port_data_in, mem_data_out, mem_data_in;
    logic [AW-1:0]     mem_address;
    logic              mem_read, mem_write, mem_ready;
    logic [1:0]        owner;

    logic [DW-1:0]     mem    [256];
    logic [DW-1:0]     shadow [256];
    int                checks = 0;
    int                failures = 0;
    int                m_owner, m_hold;

    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_address[7:0]];

    mem_arbiter #(.PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .port_valid(port_valid), .port_lock(port_lock),
        .port_address(port_address), .port_read(port_read), .port_write(port_write),
        .port_data_out(port_data_out), .port_ready(port_ready), .port_data_in(port_data_in),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
        .owner(owner)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 7 + 3);
    endfunction

    task automatic set_port(input int i, input logic v, input logic lk, input logic rd,
                            input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        port_valid[i] = v;
        port_lock[i]  = lk;
        port_read[i]  = rd;
        port_write[i] = wr;
        port_address[i*AW +: AW]  = a;
        port_data_out[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        port_valid = '0; port_lock = '0; port_read = '0; port_write = '0;
        port_address = '0; port_data_out = '0;
    endtask

    task automatic check_outputs();
        logic v, rd, wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [P-1:0]  er;
        if (rst) begin
            chk("rst_addr", mem_address, 0);
            chk("rst_wr", mem_write, 0);
            chk("rst_rd", mem_read, 0);
            chk("rst_dout", mem_data_out, 0);
            chk("rst_ready", port_ready, 0);
            chk("rst_owner", owner, 0);
        end else begin
            v  = port_valid[m_owner];
            wr = v & port_write[m_owner];
            rd = v & port_read[m_owner] & ~port_write[m_owner];
            ea = v ? port_address[m_owner*AW +: AW] : '0;
            ed = wr ? port_data_out[m_owner*DW +: DW] : '0;
            er = '0;
            er[m_owner] = mem_ready;
            chk("owner", owner, m_owner);
            chk("mem_addr", mem_address, ea);
            chk("mem_wr", mem_write, wr);
            chk("mem_rd", mem_read, rd);
            chk("mem_dout", mem_data_out, ed);
            chk("ready", port_ready, er);
            chk("data_in", port_data_in, shadow[ea[7:0]]);
        end
    endtask

    // Checks the current cycle, then advances the model and the clock to the next falling edge.
    task automatic cycle();
        int  o, no, nh;
        logic v, comp, waiting, found;
        #1 check_outputs();
        if (!rst && mem_write && mem_ready) mem[mem_address[7:0]] = mem_data_out;
        no = m_owner;
        nh = m_hold;
        if (rst) begin
            no = 0;
            nh = 0;
        end else begin
            o = m_owner;
            v = port_valid[o];
            comp = v & (port_read[o] | port_write[o]) & mem_ready;
            if (v && port_write[o] && mem_ready)
                shadow[port_address[o*AW+7 -: 8]] = port_data_out[o*DW +: DW];
            waiting = 1'b0;
            for (int j = 0; j < P; j++) if (j != o && port_valid[j]) waiting = 1'b1;
            if (waiting && (!v || (comp && (!port_lock[o] || m_hold == MH - 1)))) begin
                found = 1'b0;
                for (int k = 1; k < P; k++) begin
                    if (!found && port_valid[(o + k) % P]) begin
                        no = (o + k) % P;
                        found = 1'b1;
                    end
                end
                nh = 0;
            end else if (!waiting) begin
                nh = 0;
            end else if (comp && m_hold < MH - 1) begin
                nh = m_hold + 1;
            end
        end
        @(posedge clk);
        m_owner = no;
        m_hold  = nh;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = pat(i);
            shadow[i] = pat(i);
        end
        clear_all();
        mem_ready = 1'b1;
        rst = 1'b1;
        m_owner = 0;
        m_hold = 0;
        cycle();
        cycle();
        chk("reset_owner", owner, 0);
        rst = 1'b0;

        set_port(0, 1, 0, 1, 0, 24'o00000100, 0);
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom % 2);
            cycle();
        end
        chk("park_owner", owner, 0);

        do_reset();
        mem_ready = 1'b1;
        set_port(0, 1, 0, 1, 0, 24'o20, 0);
        set_port(1, 1, 0, 1, 0, 24'o21, 0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("alt_owner", owner, k % 2);
            chk("alt_data", port_data_in, pat((k % 2) ? 'o21 : 'o20));
            cycle();
        end

        do_reset();
        clear_all();
        set_port(0, 1, 0, 0, 1, 24'o10, 12'o1234);
        set_port(1, 1, 0, 1, 0, 24'o21, 0);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("slow_owner", owner, 0);
        end
        mem_ready = 1'b1;
        cycle();
        chk("slow_mem", mem[8], 12'o1234);
        chk("slow_handover", owner, 1);

        do_reset();
        clear_all();
        set_port(0, 1, 1, 1, 0, 24'o30, 0);
        set_port(1, 1, 0, 1, 0, 24'o31, 0);
        mem_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && owner != 2'd1; c++) begin
            #1 if (port_ready[0] && mem_read) n++;
            cycle();
        end
        chk("lock_count", n, 4);
        chk("lock_owner", owner, 1);

        do_reset();
        clear_all();
        set_port(1, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("rr_owner1", owner, 1);
        clear_all();
        set_port(0, 1, 0, 1, 0, 24'o40, 0);
        set_port(3, 1, 0, 1, 0, 24'o43, 0);
        cycle();
        chk("rr_owner3", owner, 3);
        cycle();
        chk("rr_owner0", owner, 0);

        clear_all();
        set_port(0, 1, 0, 1, 1, 24'o50, 12'o777);
        #1;
        chk("rw_write", mem_write, 1);
        chk("rw_read", mem_read, 0);
        cycle();

        clear_all();
        set_port(2, 1, 0, 0, 1, 24'o60, 12'o55);
        mem_ready = 1'b0;
        cycle();
        cycle();
        chk("mid_owner2", owner, 2);
        #2 rst = 1'b1;
        m_owner = 0;
        m_hold = 0;
        #1;
        chk("mid_rst_wr", mem_write, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_ready", port_ready, 0);
        chk("mid_rst_owner", owner, 0);
        cycle();
        rst = 1'b0;

        for (int c = 0; c < 800; c++) begin
            port_valid    = P'($urandom | $urandom);
            port_lock     = P'($urandom | $urandom);
            port_read     = P'($urandom);
            port_write    = P'($urandom);
            port_address  = {$urandom, $urandom, $urandom};
            port_data_out = 48'({$urandom, $urandom});
            mem_ready     = ($urandom % 4) != 0;
            rst           = ($urandom % 100) == 0;
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
